// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
// The state encoding and counter width are fixed so waveforms stay readable across builds.
package data_mem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mr_state_e;

  // The full 30-bit word index is compared so out-of-range addresses never alias into the RAM.
  function automatic logic req_err(input logic [31:0] addr, input logic ren,
                                   input logic wen, input logic [31:0] depth);
    return (ren & wen) | (addr[1:0] != 2'b00) | ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the CPU load/store path and the responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_ren, req_wen, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_ren, req_wen, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder_sync_ram.sv
// Word RAM with registered write and combinational read; contents are never reset.
module data_mem_responder_sync_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Accepts one data access, waits LATENCY cycles, performs it on the RAM and holds the
// response until the requester takes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mr_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic             ren_q;
  logic             wen_q;
  logic [31:0]      wdata_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;

  logic             access_err;
  logic             commit;
  logic             ram_we;
  logic [31:0]      ram_rdata;

  assign access_err = req_err(addr_q, ren_q, wen_q, 32'(DEPTH_WORDS));
  assign commit     = (state_q == MR_WAIT) && (cnt_q == '0);
  // Async reset forces IDLE at once, so a captured write can never reach the RAM.
  assign ram_we     = commit & wen_q & ~access_err;

  data_mem_responder_sync_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .raddr (addr_q[AW+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= MR_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        MR_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            ren_q   <= bus.req_ren;
            wen_q   <= bus.req_wen;
            wdata_q <= bus.req_wdata;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= MR_WAIT;
          end
        end
        MR_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= access_err;
            resp_rdata_q <= (!access_err && ren_q) ? ram_rdata : 32'h0;
            state_q      <= MR_RESP;
          end
        end
        MR_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= MR_IDLE;
          end
        end
        default: state_q <= MR_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == MR_IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 1 and 15 share one
// request driver selected by 'sel'.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic        resp_ready;
  int          sel;

  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;

  int n_checks;
  int n_fail;

  logic [31:0] rd;
  logic        er;
  int          lat;

  data_mem_responder_if if1 ();
  data_mem_responder_if if2 ();
  data_mem_responder_if if15 ();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
    .clock (clk), .reset (rst), .bus (if2.slave));
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clock (clk), .reset (rst), .bus (if1.slave));
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut15 (
    .clock (clk), .reset (rst), .bus (if15.slave));

  assign if2.req_valid   = req_valid & (sel == 2);
  assign if2.req_addr    = req_addr;
  assign if2.req_ren     = req_ren;
  assign if2.req_wen     = req_wen;
  assign if2.req_wdata   = req_wdata;
  assign if2.resp_ready  = resp_ready & (sel == 2);
  assign if1.req_valid   = req_valid & (sel == 1);
  assign if1.req_addr    = req_addr;
  assign if1.req_ren     = req_ren;
  assign if1.req_wen     = req_wen;
  assign if1.req_wdata   = req_wdata;
  assign if1.resp_ready  = resp_ready & (sel == 1);
  assign if15.req_valid  = req_valid & (sel == 15);
  assign if15.req_addr   = req_addr;
  assign if15.req_ren    = req_ren;
  assign if15.req_wen    = req_wen;
  assign if15.req_wdata  = req_wdata;
  assign if15.resp_ready = resp_ready & (sel == 15);

  always_comb begin
    o_req_ready  = if2.req_ready;
    o_resp_valid = if2.resp_valid;
    o_resp_rdata = if2.resp_rdata;
    o_resp_err   = if2.resp_err;
    case (sel)
      1: begin
        o_req_ready  = if1.req_ready;
        o_resp_valid = if1.resp_valid;
        o_resp_rdata = if1.resp_rdata;
        o_resp_err   = if1.resp_err;
      end
      15: begin
        o_req_ready  = if15.req_ready;
        o_resp_valid = if15.resp_valid;
        o_resp_rdata = if15.resp_rdata;
        o_resp_err   = if15.resp_err;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One full transaction; 'hold' keeps resp_ready low for that many extra cycles.
  task automatic xfer(input logic [31:0] a, input logic r, input logic w,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rdata, output logic err, output int edges);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    req_addr  = a;
    req_ren   = r;
    req_wen   = w;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    edges = 0;
    while (!o_resp_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    rdata = o_resp_rdata;
    err   = o_resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(o_resp_valid), 32'd1);
      check("hold_rdata", o_resp_rdata, rdata);
      check("hold_err",   32'(o_resp_err), 32'(err));
      check("hold_nordy", 32'(o_req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_clear", 32'(o_resp_valid), 32'd0);
    check("idle_after", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    sel        = 2;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_ren    = 1'b0;
    req_wen    = 1'b0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    #12;
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_valid", 32'(o_resp_valid), 32'd0);
    check("rst_rdata", o_resp_rdata, 32'h0);
    check("rst_err",   32'(o_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write then read back at LATENCY 2
    xfer(32'h40, 1'b0, 1'b1, 32'h12345678, 0, rd, er, lat);
    check("t1_wr_lat", 32'(lat), 32'd2);
    check("t1_wr_err", 32'(er), 32'd0);
    check("t1_wr_rd",  rd, 32'h0);
    xfer(32'h40, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t1_rd_lat", 32'(lat), 32'd2);
    check("t1_rd_err", 32'(er), 32'd0);
    check("t1_rd_rd",  rd, 32'h12345678);

    // Backpressure: response held for 5 cycles
    xfer(32'h40, 1'b1, 1'b0, 32'h0, 5, rd, er, lat);
    check("t2_rd_rd",  rd, 32'h12345678);
    check("t2_rd_err", 32'(er), 32'd0);

    // Reset in WAIT drops the in-flight write
    xfer(32'h10, 1'b0, 1'b1, 32'h11111111, 0, rd, er, lat);
    xfer(32'h10, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t3_pre_rd", rd, 32'h11111111);
    @(negedge clk);
    req_addr  = 32'h10;
    req_ren   = 1'b0;
    req_wen   = 1'b1;
    req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_in_wait", 32'(o_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("t3_rst_ready", 32'(o_req_ready), 32'd0);
    check("t3_rst_valid", 32'(o_resp_valid), 32'd0);
    check("t3_rst_rdata", o_resp_rdata, 32'h0);
    check("t3_rst_err",   32'(o_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(32'h10, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t3_post_rd", rd, 32'h11111111);

    // Misaligned and out-of-range accesses must not touch memory
    xfer(32'h0,   1'b0, 1'b1, 32'h0BADF00D, 0, rd, er, lat);
    xfer(32'h3FC, 1'b0, 1'b1, 32'hA5A5A5A5, 0, rd, er, lat);
    xfer(32'h42,  1'b0, 1'b1, 32'hBAD0BAD0, 0, rd, er, lat);
    check("t4_mis_err", 32'(er), 32'd1);
    check("t4_mis_rd",  rd, 32'h0);
    check("t4_mis_lat", 32'(lat), 32'd2);
    xfer(32'h400, 1'b0, 1'b1, 32'hBAD1BAD1, 0, rd, er, lat);
    check("t4_oor_err", 32'(er), 32'd1);
    check("t4_oor_rd",  rd, 32'h0);
    xfer(32'h400, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t4_oor_rerr", 32'(er), 32'd1);
    check("t4_oor_rrd",  rd, 32'h0);
    xfer(32'h40, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t4_rd40", rd, 32'h12345678);
    xfer(32'h3FC, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t4_rd3fc", rd, 32'hA5A5A5A5);
    xfer(32'h0, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t4_rd0", rd, 32'h0BADF00D);

    // ren and wen together are rejected; neither set is a clean no-op
    xfer(32'h20, 1'b0, 1'b1, 32'h55AA55AA, 0, rd, er, lat);
    xfer(32'h20, 1'b1, 1'b1, 32'hCAFEF00D, 0, rd, er, lat);
    check("t5_both_err", 32'(er), 32'd1);
    check("t5_both_rd",  rd, 32'h0);
    xfer(32'h20, 1'b0, 1'b0, 32'hCAFEF00D, 0, rd, er, lat);
    check("t5_nop_err", 32'(er), 32'd0);
    check("t5_nop_rd",  rd, 32'h0);
    xfer(32'h20, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t5_rd20", rd, 32'h55AA55AA);

    // Latency extremes
    sel = 1;
    xfer(32'h40, 1'b0, 1'b1, 32'h12345678, 0, rd, er, lat);
    check("t6_l1_wlat", 32'(lat), 32'd1);
    xfer(32'h40, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t6_l1_rlat", 32'(lat), 32'd1);
    check("t6_l1_rd",   rd, 32'h12345678);
    sel = 15;
    xfer(32'h40, 1'b0, 1'b1, 32'h12345678, 0, rd, er, lat);
    check("t6_l15_wlat", 32'(lat), 32'd15);
    xfer(32'h40, 1'b1, 1'b0, 32'h0, 0, rd, er, lat);
    check("t6_l15_rlat", 32'(lat), 32'd15);
    check("t6_l15_rd",   rd, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
